// File: rtl/apb_sram_if.sv
// rtl/apb_sram_if.sv - APB4 bus bundle between a requester and the SRAM slave
interface apb_sram_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  PSEL;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [ADDR_W-1:0]     PADDR;
    logic [DATA_W-1:0]     PWDATA;
    logic [DATA_W/8-1:0]   PSTRB;
    logic [2:0]            PPROT;
    logic                  PREADY;
    logic [DATA_W-1:0]     PRDATA;
    logic                  PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
        input  PREADY, PRDATA, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
        output PREADY, PRDATA, PSLVERR
    );
endinterface

// File: rtl/apb_sram_slave.sv
// rtl/apb_sram_slave.sv - APB4 word memory slave with wait states, byte strobes,
// read-only low region and PSLVERR for misaligned/out-of-range/read-only accesses
module apb_sram_slave #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 0,
    parameter int RO_WORDS    = 0
) (
    input  logic         PCLK,
    input  logic         PRESETn,
    apb_sram_if.slave    bus
);
    localparam int STRB_W = DATA_W / 8;
    localparam int LSB    = $clog2(STRB_W);
    localparam int IDX_W  = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] LSB_MASK = ADDR_W'((64'd1 << LSB) - 64'd1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              wr_q, wr_d;
    logic              err_q, err_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              pready_q, pready_d;
    logic              pslverr_q, pslverr_d;
    logic [DATA_W-1:0] prdata_q, prdata_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [ADDR_W-1:0] addr_idx;
    logic              misaligned, out_of_range, ro_hit, setup_err;
    logic              enter_wr, enter_err;
    logic [IDX_W-1:0]  enter_idx;
    logic [DATA_W-1:0] enter_rdata;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic              unused_pprot;

    assign unused_pprot = ^bus.PPROT;

    assign addr_idx     = bus.PADDR >> LSB;
    assign misaligned   = |(bus.PADDR & LSB_MASK);
    assign out_of_range = addr_idx >= ADDR_W'(DEPTH);

    generate
        if (RO_WORDS > 0) begin : g_ro
            assign ro_hit = bus.PWRITE && (addr_idx < ADDR_W'(RO_WORDS));
        end else begin : g_no_ro
            assign ro_hit = 1'b0;
        end
    endgenerate

    assign setup_err = misaligned || out_of_range || ro_hit;

    // With zero wait states DONE is entered straight from the setup cycle,
    // so the read source must come from the live bus rather than the latch.
    always_comb begin
        if (state_q == ST_IDLE) begin
            enter_wr  = bus.PWRITE;
            enter_err = setup_err;
            enter_idx = addr_idx[IDX_W-1:0];
        end else begin
            enter_wr  = wr_q;
            enter_err = err_q;
            enter_idx = idx_q;
        end
        enter_rdata = (!enter_wr && !enter_err) ? mem_q[enter_idx] : '0;
    end

    always_comb begin
        for (int k = 0; k < STRB_W; k++) begin
            mem_wdata[8*k +: 8] = bus.PSTRB[k] ? bus.PWDATA[8*k +: 8]
                                               : mem_q[idx_q][8*k +: 8];
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        wr_d      = wr_q;
        err_d     = err_q;
        cnt_d     = cnt_q;
        pready_d  = pready_q;
        pslverr_d = pslverr_q;
        prdata_d  = prdata_q;
        mem_we    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                pready_d  = 1'b0;
                pslverr_d = 1'b0;
                prdata_d  = '0;
                if (bus.PSEL && !bus.PENABLE) begin
                    idx_d = addr_idx[IDX_W-1:0];
                    wr_d  = bus.PWRITE;
                    err_d = setup_err;
                    cnt_d = 4'(WAIT_CYCLES);
                    if (WAIT_CYCLES == 0) begin
                        state_d   = ST_DONE;
                        pready_d  = 1'b1;
                        pslverr_d = enter_err;
                        prdata_d  = enter_rdata;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (!bus.PSEL) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == 4'd1) begin
                    state_d   = ST_DONE;
                    cnt_d     = '0;
                    pready_d  = 1'b1;
                    pslverr_d = enter_err;
                    prdata_d  = enter_rdata;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_DONE: begin
                if (!bus.PSEL || bus.PENABLE) begin
                    mem_we    = bus.PSEL && wr_q && !err_q;
                    state_d   = ST_IDLE;
                    pready_d  = 1'b0;
                    pslverr_d = 1'b0;
                    prdata_d  = '0;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                pready_d  = 1'b0;
                pslverr_d = 1'b0;
                prdata_d  = '0;
            end
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            wr_q      <= 1'b0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            wr_q      <= wr_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            prdata_q  <= prdata_d;
        end
    end

    // Each word resets to its own index so reads are predictable before any write.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= DATA_W'(i);
            end
        end else if (mem_we) begin
            mem_q[idx_q] <= mem_wdata;
        end
    end

    assign bus.PREADY  = pready_q;
    assign bus.PSLVERR = pslverr_q;
    assign bus.PRDATA  = prdata_q;
endmodule

// File: tb/tb_apb_sram_slave.sv
// tb/tb_apb_sram_slave.sv - directed checks of apb_sram_slave across four parameter sets
module tb_apb_sram_slave;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        rst_c;
    logic        psel, penable, pwrite;
    logic [31:0] paddr;
    logic [63:0] pwdata;
    logic [7:0]  pstrb;
    int          sel;
    logic        rd_pready, rd_pslverr;
    logic [63:0] rd_prdata;
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    apb_sram_if #(.ADDR_W(32), .DATA_W(32)) if_a ();
    apb_sram_if #(.ADDR_W(32), .DATA_W(32)) if_b ();
    apb_sram_if #(.ADDR_W(32), .DATA_W(32)) if_c ();
    apb_sram_if #(.ADDR_W(32), .DATA_W(64)) if_d ();

    assign if_a.PSEL = psel && (sel == 0);
    assign if_b.PSEL = psel && (sel == 1);
    assign if_c.PSEL = psel && (sel == 2);
    assign if_d.PSEL = psel && (sel == 3);
    assign if_a.PENABLE = penable;  assign if_b.PENABLE = penable;
    assign if_c.PENABLE = penable;  assign if_d.PENABLE = penable;
    assign if_a.PWRITE  = pwrite;   assign if_b.PWRITE  = pwrite;
    assign if_c.PWRITE  = pwrite;   assign if_d.PWRITE  = pwrite;
    assign if_a.PADDR   = paddr;    assign if_b.PADDR   = paddr;
    assign if_c.PADDR   = paddr;    assign if_d.PADDR   = paddr;
    assign if_a.PWDATA  = pwdata[31:0];  assign if_b.PWDATA = pwdata[31:0];
    assign if_c.PWDATA  = pwdata[31:0];  assign if_d.PWDATA = pwdata;
    assign if_a.PSTRB   = pstrb[3:0];    assign if_b.PSTRB  = pstrb[3:0];
    assign if_c.PSTRB   = pstrb[3:0];    assign if_d.PSTRB  = pstrb;
    assign if_a.PPROT   = 3'b000;   assign if_b.PPROT   = 3'b010;
    assign if_c.PPROT   = 3'b001;   assign if_d.PPROT   = 3'b000;

    apb_sram_slave #(.DATA_W(32), .ADDR_W(32), .DEPTH(256), .WAIT_CYCLES(0), .RO_WORDS(4))
        u_a (.PCLK(clk), .PRESETn(rst_n), .bus(if_a));
    apb_sram_slave #(.DATA_W(32), .ADDR_W(32), .DEPTH(256), .WAIT_CYCLES(3), .RO_WORDS(0))
        u_b (.PCLK(clk), .PRESETn(rst_n), .bus(if_b));
    apb_sram_slave #(.DATA_W(32), .ADDR_W(32), .DEPTH(256), .WAIT_CYCLES(2), .RO_WORDS(0))
        u_c (.PCLK(clk), .PRESETn(rst_c), .bus(if_c));
    apb_sram_slave #(.DATA_W(64), .ADDR_W(32), .DEPTH(256), .WAIT_CYCLES(0), .RO_WORDS(0))
        u_d (.PCLK(clk), .PRESETn(rst_n), .bus(if_d));

    always_comb begin
        rd_pready  = 1'b0;
        rd_pslverr = 1'b0;
        rd_prdata  = '0;
        case (sel)
            0: begin rd_pready = if_a.PREADY; rd_pslverr = if_a.PSLVERR; rd_prdata = {32'b0, if_a.PRDATA}; end
            1: begin rd_pready = if_b.PREADY; rd_pslverr = if_b.PSLVERR; rd_prdata = {32'b0, if_b.PRDATA}; end
            2: begin rd_pready = if_c.PREADY; rd_pslverr = if_c.PSLVERR; rd_prdata = {32'b0, if_c.PRDATA}; end
            default: begin rd_pready = if_d.PREADY; rd_pslverr = if_d.PSLVERR; rd_prdata = if_d.PRDATA; end
        endcase
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Full transfer; cyc counts setup plus every access cycle up to and including PREADY=1.
    task automatic apb_xfer(input int s, input logic w, input logic [31:0] a,
                            input logic [63:0] d, input logic [7:0] st,
                            output logic [63:0] rd, output logic er, output int cyc);
        int n;
        @(posedge clk); #1;
        sel = s; psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = d; pstrb = st;
        @(posedge clk); #1;
        penable = 1'b1;
        n = 0;
        rd = '0;
        er = 1'b0;
        while (n < 40) begin
            @(negedge clk);
            n++;
            if (rd_pready) begin
                rd = rd_prdata;
                er = rd_pslverr;
                break;
            end
            @(posedge clk); #1;
        end
        if (n >= 40) check_eq("pready_timeout", 64'd0, 64'd1);
        cyc = n + 1;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    logic [63:0] rd;
    logic        er;
    int          cyc;

    initial begin
        sel = 0; psel = 0; penable = 0; pwrite = 0; paddr = '0; pwdata = '0; pstrb = '0;
        rst_n = 1'b0; rst_c = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("reset_pready", {63'b0, rd_pready}, 64'd0);
        check_eq("reset_pslverr", {63'b0, rd_pslverr}, 64'd0);
        check_eq("reset_prdata", rd_prdata, 64'd0);
        rst_n = 1'b1; rst_c = 1'b1;

        // Instance A: 32-bit, zero wait, words 0..3 read-only
        apb_xfer(0, 1'b0, 32'h10, 64'd0, 8'h0, rd, er, cyc);
        check_eq("t1_rdata", rd, 64'h4);
        check_eq("t1_err", {63'b0, er}, 64'd0);
        check_eq("t1_cycles", 64'(cyc), 64'd2);
        @(negedge clk);
        check_eq("t1_pready_clear", {63'b0, rd_pready}, 64'd0);
        check_eq("t1_prdata_clear", rd_prdata, 64'd0);

        apb_xfer(0, 1'b1, 32'h20, 64'hAABBCCDD, 8'h5, rd, er, cyc);
        check_eq("t2_wr_err", {63'b0, er}, 64'd0);
        check_eq("t2_wr_rdata", rd, 64'd0);
        apb_xfer(0, 1'b0, 32'h20, 64'd0, 8'h0, rd, er, cyc);
        check_eq("t2_rdata", rd, 64'h00BB00DD);

        apb_xfer(0, 1'b1, 32'h24, 64'h12345678, 8'h0, rd, er, cyc);
        check_eq("zero_strb_err", {63'b0, er}, 64'd0);
        apb_xfer(0, 1'b0, 32'h24, 64'd0, 8'h0, rd, er, cyc);
        check_eq("zero_strb_rdata", rd, 64'h9);

        apb_xfer(0, 1'b0, 32'h402, 64'd0, 8'h0, rd, er, cyc);
        check_eq("t4_misalign_err", {63'b0, er}, 64'd1);
        check_eq("t4_misalign_rdata", rd, 64'd0);
        apb_xfer(0, 1'b0, 32'h0E, 64'd0, 8'h0, rd, er, cyc);
        check_eq("misalign_inrange_err", {63'b0, er}, 64'd1);
        apb_xfer(0, 1'b1, 32'h400, 64'hFFFFFFFF, 8'hF, rd, er, cyc);
        check_eq("t4_range_err", {63'b0, er}, 64'd1);
        apb_xfer(0, 1'b0, 32'h3FC, 64'd0, 8'h0, rd, er, cyc);
        check_eq("last_word_err", {63'b0, er}, 64'd0);
        check_eq("last_word_rdata", rd, 64'hFF);
        apb_xfer(0, 1'b0, 32'h0, 64'd0, 8'h0, rd, er, cyc);
        check_eq("word0_unchanged", rd, 64'h0);

        apb_xfer(0, 1'b1, 32'h08, 64'hDEADBEEF, 8'hF, rd, er, cyc);
        check_eq("t4_ro_err", {63'b0, er}, 64'd1);
        apb_xfer(0, 1'b0, 32'h08, 64'd0, 8'h0, rd, er, cyc);
        check_eq("t4_ro_rdata", rd, 64'h2);
        check_eq("t4_ro_read_err", {63'b0, er}, 64'd0);
        apb_xfer(0, 1'b1, 32'h10, 64'hCAFEF00D, 8'hF, rd, er, cyc);
        check_eq("ro_boundary_err", {63'b0, er}, 64'd0);
        apb_xfer(0, 1'b0, 32'h10, 64'd0, 8'h0, rd, er, cyc);
        check_eq("ro_boundary_rdata", rd, 64'hCAFEF00D);

        // Instance B: three wait states
        apb_xfer(1, 1'b1, 32'h30, 64'h12345678, 8'hF, rd, er, cyc);
        check_eq("t3_wr_cycles", 64'(cyc), 64'd5);
        apb_xfer(1, 1'b0, 32'h04, 64'd0, 8'h0, rd, er, cyc);
        check_eq("t3_rd_cycles", 64'(cyc), 64'd5);
        check_eq("t3_rdata", rd, 64'h1);
        apb_xfer(1, 1'b0, 32'h30, 64'd0, 8'h0, rd, er, cyc);
        check_eq("t3_wr_readback", rd, 64'h12345678);

        // Instance C: two wait states, abort and reset mid-transfer
        @(posedge clk); #1;
        sel = 2; psel = 1; penable = 0; pwrite = 1; paddr = 32'h0C; pwdata = 64'h77; pstrb = 8'hF;
        @(posedge clk); #1;
        penable = 1;
        @(negedge clk);
        check_eq("t5_wait_pready", {63'b0, rd_pready}, 64'd0);
        @(posedge clk); #1;
        psel = 0; penable = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("t5_abort_pready", {63'b0, rd_pready}, 64'd0);
        apb_xfer(2, 1'b0, 32'h0C, 64'd0, 8'h0, rd, er, cyc);
        check_eq("t5_abort_rdata", rd, 64'h3);
        check_eq("t5_rd_cycles", 64'(cyc), 64'd4);

        apb_xfer(2, 1'b1, 32'h0C, 64'h55, 8'hF, rd, er, cyc);
        apb_xfer(2, 1'b0, 32'h0C, 64'd0, 8'h0, rd, er, cyc);
        check_eq("t5_written", rd, 64'h55);

        @(posedge clk); #1;
        sel = 2; psel = 1; penable = 0; pwrite = 1; paddr = 32'h0C; pwdata = 64'h99; pstrb = 8'hF;
        @(posedge clk); #1;
        penable = 1;
        @(posedge clk); #2;
        rst_c = 1'b0;
        #1;
        check_eq("t5_rst_pready", {63'b0, rd_pready}, 64'd0);
        check_eq("t5_rst_pslverr", {63'b0, rd_pslverr}, 64'd0);
        check_eq("t5_rst_prdata", rd_prdata, 64'd0);
        psel = 0; penable = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_c = 1'b1;
        apb_xfer(2, 1'b0, 32'h0C, 64'd0, 8'h0, rd, er, cyc);
        check_eq("t5_reinit", rd, 64'h3);

        // Instance D: 64-bit lanes
        apb_xfer(3, 1'b1, 32'h18, 64'h1122334455667788, 8'hF0, rd, er, cyc);
        check_eq("t6_wr_err", {63'b0, er}, 64'd0);
        apb_xfer(3, 1'b0, 32'h18, 64'd0, 8'h0, rd, er, cyc);
        check_eq("t6_rdata", rd, 64'h1122334400000003);
        apb_xfer(3, 1'b0, 32'h1C, 64'd0, 8'h0, rd, er, cyc);
        check_eq("t6_misalign_err", {63'b0, er}, 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
